// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the fetch stage and its helpers.
//   - XLEN:            machine word width (32)
//   - fetch_state_e:   fetch controller states (IDLE, REQ, HOLD, DROP)
//   - NOP_WORD:        MIPS sll $0,$0,0, presented in IF/ID on bubbles
//   - RT/RD/IMM bit positions inside an instruction word
//   - sext16():        sign-extend a 16-bit immediate to XLEN
package pipe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register for a fetched instruction that
// arrived while Decode was stalled.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load_i             capture instr_i / pc4_i and mark the entry valid
//   clear_i            invalidate the entry (wins over load_i)
//   instr_i, pc4_i     instruction word and its PC+4
//   instr_o, pc4_o     held contents
//   valid_o            entry holds an instruction
module fetch_skid
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc4_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus the IF/ID pipeline register.
// Owns the PC, talks req/valid to instruction memory, honours stall from
// the hazard unit and redirects from branch/jump resolution.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   stall_i                  hold IF/ID and PC
//   redirect_i/redirect_pc_i branch/jump redirect and its target
//   imem_req/imem_addr       fetch request and word-aligned address
//   imem_valid/imem_rdata    fetch response
//   instr_F, valid_F         IF/ID instruction and its valid flag
//   instru2016/instru1511    rt / rd fields of instr_F
//   oinstru                  sign-extended immediate of instr_F
//   sum2sumOF                PC+4 of instr_F
// Optional: define FETCH_PERF_CNT_EN to add saturating counters
//   perf_fetched / perf_stall / perf_flush.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_F,
  output logic [4:0]      instru2016,
  output logic [4:0]      instru1511,
  output logic [XLEN-1:0] oinstru,
  output logic [XLEN-1:0] sum2sumOF,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush,
`endif
  output logic            valid_F
);

  fetch_state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] pc_plus4;

  logic [XLEN-1:0] ifid_instr_q;
  logic [XLEN-1:0] ifid_pc4_q;
  logic            ifid_valid_q;

  logic            if_load;
  logic            if_bubble;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc4;
  logic            load_valid;

  logic            skid_load;
  logic            skid_clear;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc4;
  logic            skid_valid;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc_q + 32'd4;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_i)                 state_d = imem_valid ? REQ : DROP;
        else if (imem_valid && stall_i) state_d = HOLD;
      end
      HOLD: begin
        if (redirect_i || !stall_i) state_d = REQ;
      end
      // A redirect without a response keeps waiting for the stale one.
      DROP: begin
        if (imem_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // In DROP the outstanding request must keep its original address even
  // though pc_q already points at the redirect target.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      REQ:  imem_req = 1'b1;
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // ---------------- datapath control ----------------
  always_comb begin
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    if_load     = 1'b0;
    if_bubble   = 1'b0;
    load_instr  = skid_instr;
    load_pc4    = skid_pc4;
    load_valid  = skid_valid;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    if (redirect_i) begin
      // Redirect overrides stall and any response arriving this cycle.
      pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
      if_bubble  = 1'b1;
      skid_clear = 1'b1;
      if (state_q == REQ && !imem_valid) drop_addr_d = pc_q;
    end else begin
      case (state_q)
        REQ: begin
          if (imem_valid && !stall_i) begin
            if_load    = 1'b1;
            load_instr = imem_rdata;
            load_pc4   = pc_plus4;
            load_valid = 1'b1;
            pc_d       = pc_plus4;
          end else if (imem_valid) begin
            skid_load = 1'b1;
          end else if (!stall_i) begin
            if_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            if_load    = 1'b1;
            pc_d       = pc_plus4;
            skid_clear = 1'b1;
          end
        end
        // IDLE and DROP deliver nothing; insert a bubble unless stalled.
        default: begin
          if (!stall_i) if_bubble = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // ---------------- IF/ID register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (if_bubble) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (if_load) begin
      ifid_instr_q <= load_instr;
      ifid_pc4_q   <= load_pc4;
      ifid_valid_q <= load_valid;
    end
  end

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc4_i   (pc_plus4),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4),
    .valid_o (skid_valid)
  );

  assign instr_F    = ifid_instr_q;
  assign sum2sumOF  = ifid_pc4_q;
  assign valid_F    = ifid_valid_q;
  assign instru2016 = ifid_instr_q[RT_MSB:RT_LSB];
  assign instru1511 = ifid_instr_q[RD_MSB:RD_LSB];
  assign oinstru    = sext16(ifid_instr_q[IMM_MSB:IMM_LSB]);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      if (if_load && !if_bubble && (perf_fetched_q != '1))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall_i && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_i && (perf_flush_q != '1))
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Memory returns addr ^ 32'hA5A5_0000
// (address 0x0C returns 0x2128FFFC) with a configurable number of wait
// states. A second instance built with RESET_PC=0xFFFFFFF8 covers PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, rst_w_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_F, oinstru, sum2sumOF;
  logic [4:0]  instru2016, instru1511;
  logic        valid_F;

  logic        req_w, vld_w;
  logic [31:0] addr_w, rdata_w, instr_w, imm_w, sum_w;
  logic [4:0]  rt_w, rd_w;
  logic        valid_w;
  logic        stall_w = 1'b0;
  logic        redirect_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_a, ps_a, pl_a, pf_b, ps_b, pl_b;
`endif

  int waits = 0;
  int wait_cnt = 0;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] SPECIAL_ADDR = 32'h0000_000C;
  localparam logic [31:0] SPECIAL_DATA = 32'h2128_FFFC;

  always #5 clk = ~clk;

  assign imem_valid = imem_req && (wait_cnt >= waits);
  assign imem_rdata = (imem_addr == SPECIAL_ADDR) ? SPECIAL_DATA
                                                   : (imem_addr ^ 32'hA5A5_0000);
  always @(posedge clk) begin
    if (!imem_req || imem_valid) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  assign vld_w   = req_w;
  assign rdata_w = addr_w ^ 32'hA5A5_0000;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .instr_F       (instr_F),
    .instru2016    (instru2016),
    .instru1511    (instru1511),
    .oinstru       (oinstru),
    .sum2sumOF     (sum2sumOF),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched  (pf_a),
    .perf_stall    (ps_a),
    .perf_flush    (pl_a),
`endif
    .valid_F       (valid_F)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk           (clk),
    .rst_n         (rst_w_n),
    .stall_i       (stall_w),
    .redirect_i    (redirect_w),
    .redirect_pc_i (redirect_pc_w),
    .imem_req      (req_w),
    .imem_addr     (addr_w),
    .imem_valid    (vld_w),
    .imem_rdata    (rdata_w),
    .instr_F       (instr_w),
    .instru2016    (rt_w),
    .instru1511    (rd_w),
    .oinstru       (imm_w),
    .sum2sumOF     (sum_w),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched  (pf_b),
    .perf_stall    (ps_b),
    .perf_flush    (pl_b),
`endif
    .valid_F       (valid_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; rst_w_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();

    check_eq("rst_instr", instr_F, 32'h0);
    check_eq("rst_sum",   sum2sumOF, 32'h0);
    check_eq("rst_valid", {31'b0, valid_F}, 32'h0);
    check_eq("rst_req",   {31'b0, imem_req}, 32'h0);
    check_eq("rst_rt",    {27'b0, instru2016}, 32'h0);
    check_eq("rst_imm",   oinstru, 32'h0);

    rst_n = 1'b1;
    tick();  // IDLE -> REQ
    check_eq("req_up",   {31'b0, imem_req}, 32'h1);
    check_eq("addr0",    imem_addr, 32'h0);
    check_eq("idle_vld", {31'b0, valid_F}, 32'h0);
    tick();
    check_eq("sum4",   sum2sumOF, 32'h4);
    check_eq("vld1",   {31'b0, valid_F}, 32'h1);
    check_eq("instr0", instr_F, 32'hA5A5_0000);
    tick();
    check_eq("sum8",   sum2sumOF, 32'h8);
    check_eq("instr4", instr_F, 32'hA5A5_0004);
    tick();
    check_eq("sum12",  sum2sumOF, 32'hC);
    tick();
    check_eq("sum16",  sum2sumOF, 32'h10);
    check_eq("instrC", instr_F, 32'h2128_FFFC);
    check_eq("rt",     {27'b0, instru2016}, 32'd8);
    check_eq("rd",     {27'b0, instru1511}, 32'd31);
    check_eq("imm",    oinstru, 32'hFFFF_FFFC);

    // Three stall cycles; the word at 0x10 lands in the skid register.
    stall = 1'b1;
    tick();
    check_eq("stl1_sum", sum2sumOF, 32'h10);
    check_eq("stl1_req", {31'b0, imem_req}, 32'h0);
    tick();
    check_eq("stl2_ins", instr_F, 32'h2128_FFFC);
    tick();
    check_eq("stl3_sum", sum2sumOF, 32'h10);
    check_eq("stl3_pc",  imem_addr, 32'h10);
    stall = 1'b0;
    tick();
    check_eq("skid_sum", sum2sumOF, 32'h14);
    check_eq("skid_ins", instr_F, 32'hA5A5_0010);
    check_eq("skid_vld", {31'b0, valid_F}, 32'h1);
    tick();
    check_eq("post_sum", sum2sumOF, 32'h18);
    check_eq("post_ins", instr_F, 32'hA5A5_0014);

    // Redirect during stall: redirect wins, target aligned down.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    check_eq("rd_vld",  {31'b0, valid_F}, 32'h0);
    check_eq("rd_ins",  instr_F, 32'h0);
    check_eq("rd_sum",  sum2sumOF, 32'h0);
    check_eq("rd_addr", imem_addr, 32'h100);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check_eq("tg_sum", sum2sumOF, 32'h104);
    check_eq("tg_ins", instr_F, 32'hA5A5_0100);

    // Two wait states; redirect in the first wait cycle.
    waits = 2;
    tick();
    check_eq("ws_bub",  {31'b0, valid_F}, 32'h0);
    check_eq("ws_addr", imem_addr, 32'h104);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    check_eq("drop_req",  {31'b0, imem_req}, 32'h1);
    check_eq("drop_addr", imem_addr, 32'h104);
    redirect = 1'b0;
    tick();
    check_eq("drop_vld", {31'b0, valid_F}, 32'h0);
    check_eq("new_addr", imem_addr, 32'h200);
    n = 0;
    while (!valid_F && n < 10) begin
      tick();
      n++;
    end
    check_eq("ws_bound", (n < 10) ? 32'h1 : 32'h0, 32'h1);
    check_eq("ws_sum",   sum2sumOF, 32'h204);
    check_eq("ws_ins",   instr_F, 32'hA5A5_0200);

    // Asynchronous reset in the middle of a zero-wait stream.
    waits = 0;
    tick();
    tick();
    check_eq("pre_rst_vld", {31'b0, valid_F}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", {31'b0, valid_F}, 32'h0);
    check_eq("arst_ins", instr_F, 32'h0);
    check_eq("arst_sum", sum2sumOF, 32'h0);
    check_eq("arst_req", {31'b0, imem_req}, 32'h0);

    // PC wrap on the RESET_PC=0xFFFFFFF8 instance.
    rst_w_n = 1'b1;
    tick();
    check_eq("w_addr0", addr_w, 32'hFFFF_FFF8);
    tick();
    check_eq("w_sum0",  sum_w, 32'hFFFF_FFFC);
    tick();
    check_eq("w_sum1",  sum_w, 32'h0000_0000);
    check_eq("w_ins1",  instr_w, 32'h5A5A_FFFC);
    check_eq("w_vld1",  {31'b0, valid_w}, 32'h1);
    check_eq("w_addr1", addr_w, 32'h0);
    tick();
    check_eq("w_sum2",  sum_w, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
